// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between fetch (IF) and data (MEM) ports; data has fixed priority.
// Latency: 2 cycles minimum from request to valid pulse; at most one access every 2 cycles.
// Backpressure: a port's req is held (and its stall output stays high) until its one-cycle valid; optional ARB_TIMEOUT_EN aborts hung accesses.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_valid_q, i_valid_d;
    logic          d_valid_q, d_valid_d;
    logic          expire;     // access has run out of cycles without m_ack
    logic          d_elig, i_elig;

    // A requester still holding req during its own valid cycle is not re-served.
    assign d_elig = d_req & ~d_valid_q;
    assign i_elig = i_req & ~i_valid_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign expire = (state_q != IDLE) && !m_ack && (cnt_q == CW'(TIMEOUT - 1));
    assign err    = err_q;

    // Access-cycle counter: held at zero in IDLE so it starts clean on entry; saturates at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!m_ack && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (expire) begin
            err_d = 1'b1;
        end
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    // Without the timeout the FSM waits for m_ack forever and never flags an error.
    assign expire = 1'b0;
    assign err    = (TIMEOUT < 0);
`endif

    // Next-state and registered-output logic; m_ack in IDLE falls through untouched.
    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_valid_d = 1'b0;
        d_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_elig) begin
                    m_addr_d  = d_addr;
                    m_we_d    = d_we;
                    m_wdata_d = d_wdata;
                    m_req_d   = 1'b1;
                    state_d   = D_ACC;
                end else if (i_elig) begin
                    m_addr_d = i_addr;
                    m_we_d   = 1'b0;
                    m_req_d  = 1'b1;
                    state_d  = I_ACC;
                end else begin
                    m_req_d = 1'b0;
                end
            end
            D_ACC: begin
                if (m_ack || expire) begin
                    m_req_d   = 1'b0;
                    d_valid_d = 1'b1;
                    state_d   = IDLE;
                    if (!m_we_q) begin
                        d_rdata_d = m_ack ? m_rdata : '0;
                    end
                end
            end
            I_ACC: begin
                if (m_ack || expire) begin
                    m_req_d   = 1'b0;
                    i_valid_d = 1'b1;
                    i_rdata_d = m_ack ? m_rdata : '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                m_req_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
        end
    end

    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_valid   = i_valid_q;
    assign d_valid   = d_valid_q;
    assign stall_if  = i_req & ~i_valid_q;
    assign stall_mem = d_req & ~d_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: scoreboard bench for mem_port_arbiter with a latency-programmable memory model.
// Latency: expected memory requests and completions are queued at stimulus time, popped as the DUT emits them.
// Backpressure: requesters hold req until valid, then release one edge later.
module tb_mem_port_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_valid, d_valid;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        stall_if, stall_mem, busy, err;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wdata;
    } mreq_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
    } rsp_t;

    mreq_t       exp_mreq_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] exp_i_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] exp_last_i = '0;
    logic [31:0] exp_last_d = '0;

    // Memory model: acks the lat-th negedge sample of a new m_req; spur_req fires a lone ack.
    bit   mem_en   = 1'b1;
    bit   spur_req = 1'b0;
    bit   in_acc   = 1'b0;
    int   acc_cnt  = 0;
    rsp_t cur_rsp;

    initial begin
        m_ack   = 1'b0;
        m_rdata = '0;
        cur_rsp = '{lat: 1, rdata: '0};
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (spur_req) begin
                m_ack    = 1'b1;
                m_rdata  = 32'hDEADBEEF;
                spur_req = 1'b0;
            end else if (in_acc) begin
                acc_cnt++;
            end else if (m_req && mem_en && rsp_q.size() > 0) begin
                cur_rsp = rsp_q.pop_front();
                in_acc  = 1'b1;
                acc_cnt = 1;
            end
            if (in_acc && acc_cnt >= cur_rsp.lat) begin
                m_ack   = 1'b1;
                m_rdata = cur_rsp.rdata;
                in_acc  = 1'b0;
            end
        end
    end

    // Monitor: checks each new memory request, address hold, and every valid pulse.
    mreq_t cur_mreq;
    bit    m_req_prev = 1'b0;
    initial begin
        cur_mreq = '{we: 1'b0, addr: '0, wdata: '0, chk_wdata: 1'b0};
        forever begin
            @(negedge clk);
            if (m_req) begin
                if (!m_req_prev) begin
                    if (exp_mreq_q.size() == 0) begin
                        chk("m_req_unexpected", 32'd1, 32'd0);
                    end else begin
                        cur_mreq = exp_mreq_q.pop_front();
                        chk("m_we", {31'd0, m_we}, {31'd0, cur_mreq.we});
                        chk("m_addr", m_addr, cur_mreq.addr);
                        if (cur_mreq.chk_wdata) chk("m_wdata", m_wdata, cur_mreq.wdata);
                    end
                end else begin
                    chk("m_addr_hold", m_addr, cur_mreq.addr);
                end
            end
            m_req_prev = m_req;
            if (d_valid) begin
                if (exp_d_q.size() == 0) chk("d_valid_unexpected", 32'd1, 32'd0);
                else chk("d_rdata", d_rdata, exp_d_q.pop_front());
            end
            if (i_valid) begin
                if (exp_i_q.size() == 0) chk("i_valid_unexpected", 32'd1, 32'd0);
                else chk("i_rdata", i_rdata, exp_i_q.pop_front());
            end
        end
    end

    // Wait for i_valid (bounded), optionally checking stall_if, then release i_req one edge later.
    task automatic wait_i(input bit chk_stall, output int c);
        c = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (i_valid) begin
                c = cyc;
                if (chk_stall) chk("stall_if_at_valid", {31'd0, stall_if}, 32'd0);
                break;
            end
            if (chk_stall) chk("stall_if_wait", {31'd0, stall_if}, 32'd1);
        end
        if (c < 0) chk("i_valid_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 i_req = 1'b0;
    endtask

    task automatic wait_d(input bit chk_stall, output int c);
        c = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (d_valid) begin
                c = cyc;
                if (chk_stall) chk("stall_mem_at_valid", {31'd0, stall_mem}, 32'd0);
                break;
            end
            if (chk_stall) chk("stall_mem_wait", {31'd0, stall_mem}, 32'd1);
        end
        if (c < 0) chk("d_valid_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 d_req = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_m_req"}, {31'd0, m_req}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_i_valid"}, {31'd0, i_valid}, 32'd0);
        chk({tag, "_d_valid"}, {31'd0, d_valid}, 32'd0);
        chk({tag, "_i_rdata"}, i_rdata, exp_last_i);
        chk({tag, "_d_rdata"}, d_rdata, exp_last_d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int c0, ci, cd, mcnt;

    initial begin
        reset = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk_quiet("rst");
        chk("rst_m_we", {31'd0, m_we}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b1;

        // Fetch only, ack after 3 cycles.
        @(negedge clk);
        rsp_q.push_back('{lat: 3, rdata: 32'h8C220004});
        exp_mreq_q.push_back('{we: 1'b0, addr: 32'h40, wdata: '0, chk_wdata: 1'b0});
        exp_i_q.push_back(32'h8C220004);
        exp_last_i = 32'h8C220004;
        i_req = 1'b1; i_addr = 32'h40;
        c0 = cyc;
        wait_i(1'b1, ci);
        chk("fetch_latency", ci - c0, 32'd4);

        // Simultaneous load and fetch: data first, fetch two cycles later.
        @(negedge clk);
        rsp_q.push_back('{lat: 1, rdata: 32'h11111111});
        rsp_q.push_back('{lat: 1, rdata: 32'h22222222});
        exp_mreq_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, chk_wdata: 1'b1});
        exp_mreq_q.push_back('{we: 1'b0, addr: 32'h44, wdata: '0, chk_wdata: 1'b0});
        exp_d_q.push_back(32'h11111111);
        exp_i_q.push_back(32'h22222222);
        exp_last_d = 32'h11111111;
        exp_last_i = 32'h22222222;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h0;
        i_req = 1'b1; i_addr = 32'h44;
        c0 = cyc;
        fork
            wait_d(1'b1, cd);
            wait_i(1'b1, ci);
        join
        chk("load_min_latency", cd - c0, 32'd2);
        chk("d_before_i_gap", ci - cd, 32'd2);

        // Store: write data forwarded, d_rdata keeps the previous load value.
        @(negedge clk);
        rsp_q.push_back('{lat: 2, rdata: 32'h5555AAAA});
        exp_mreq_q.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'hCAFEF00D, chk_wdata: 1'b1});
        exp_d_q.push_back(exp_last_d);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hCAFEF00D;
        wait_d(1'b1, cd);
        d_we = 1'b0;

        // Fetch req dropped early: the latched access still completes.
        @(negedge clk);
        rsp_q.push_back('{lat: 3, rdata: 32'h0BADCAFE});
        exp_mreq_q.push_back('{we: 1'b0, addr: 32'h80, wdata: '0, chk_wdata: 1'b0});
        exp_i_q.push_back(32'h0BADCAFE);
        exp_last_i = 32'h0BADCAFE;
        i_req = 1'b1; i_addr = 32'h80;
        @(posedge clk);
        #1 i_req = 1'b0;
        wait_i(1'b0, ci);

        // Spurious ack in IDLE changes nothing.
        @(posedge clk);
        #1 spur_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_quiet("spur");
        end

`ifdef ARB_TIMEOUT_EN
        // Load with no ack: abort after TO access cycles, zero data, sticky err.
        mem_en = 1'b0;
        @(negedge clk);
        exp_mreq_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, chk_wdata: 1'b1});
        exp_d_q.push_back(32'h0);
        exp_last_d = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h0;
        mcnt = 0;
        cd = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (d_valid) begin
                cd = cyc;
                break;
            end
            if (m_req) mcnt++;
        end
        if (cd < 0) chk("timeout_valid_missing", 32'd0, 32'd1);
        chk("timeout_mreq_cycles", mcnt, TO);
        chk("timeout_m_req_low", {31'd0, m_req}, 32'd0);
        chk("timeout_err", {31'd0, err}, 32'd1);
        @(posedge clk);
        #1 d_req = 1'b0;
        mem_en = 1'b1;
        @(negedge clk);
        rsp_q.push_back('{lat: 1, rdata: 32'h12345678});
        exp_mreq_q.push_back('{we: 1'b0, addr: 32'h340, wdata: '0, chk_wdata: 1'b0});
        exp_i_q.push_back(32'h12345678);
        exp_last_i = 32'h12345678;
        i_req = 1'b1; i_addr = 32'h340;
        wait_i(1'b1, ci);
        chk("err_sticky", {31'd0, err}, 32'd1);
`else
        chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

        // Reset two cycles into I_ACC; a late ack afterwards is ignored.
        mem_en = 1'b0;
        @(negedge clk);
        exp_mreq_q.push_back('{we: 1'b0, addr: 32'hC0, wdata: '0, chk_wdata: 1'b0});
        i_req = 1'b1; i_addr = 32'hC0;
        @(negedge clk);
        chk("rstmid_busy_before", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        exp_last_i = '0;
        exp_last_d = '0;
        chk("rstmid_m_req", {31'd0, m_req}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_err", {31'd0, err}, 32'd0);
        i_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 spur_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk_quiet("rstmid");
        end
        mem_en = 1'b1;

        chk("mreq_queue_drained", exp_mreq_q.size(), 32'd0);
        chk("d_queue_drained", exp_d_q.size(), 32'd0);
        chk("i_queue_drained", exp_i_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the instruction-fetch port and the data (load/store) port of the 5-stage pipeline.
- The data port has fixed priority over fetch, because the MEM-stage access is the older instruction.
- Each port uses a req/valid handshake; the block generates the stall signals the pipeline needs to freeze IF and MEM while their access is outstanding.
- Sits between the IF/MEM stages and the memory model, replacing separate instruction and data memories.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, number of access-state cycles without m_ack before abort; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_valid.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetched word, registered.
- i_valid  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data, registered.
- d_valid  out  1  one-cycle completion pulse for data.
- m_req  out  1  memory request, registered.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data, valid with m_ack.
- m_ack  in  1  memory completion, one cycle.
- stall_if  out  1  i_req & ~i_valid, combinational.
- stall_mem  out  1  d_req & ~d_valid, combinational.
- busy  out  1  FSM not in IDLE.
- err  out  1  sticky timeout flag (optional feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - m_req, m_we, m_addr, m_wdata, i_rdata, d_rdata, i_valid, d_valid, err are all 0.
- FSM states: IDLE, D_ACC, I_ACC.
- IDLE:
  - A port's req is ignored in any cycle where that port's valid is high, so a requester still holding req in its valid cycle is not re-served.
  - If d_req is eligible: latch d_addr, d_we and d_wdata into m_addr, m_we and m_wdata; set m_req=1; go to D_ACC.
  - Else if i_req is eligible: latch i_addr into m_addr; set m_we=0 and m_req=1; go to I_ACC.
  - Else stay in IDLE with m_req=0.
  - If both requests are eligible in the same cycle, data wins; fetch is served on the next IDLE visit.
- D_ACC / I_ACC:
  - Hold m_req, m_addr, m_we and m_wdata stable. Port input changes are ignored because the request is already latched.
  - On a rising edge with m_ack=1: clear m_req and return to IDLE.
  - D_ACC completion: pulse d_valid for the next cycle. For a load, d_rdata <= m_rdata; for a store, d_rdata is unchanged.
  - I_ACC completion: i_rdata <= m_rdata and pulse i_valid for the next cycle.
- Latency:
  - Request seen at edge N gives m_req=1 after edge N.
  - Ack sampled at edge N+k (k>=1) gives valid high during cycle N+k.
  - Minimum request-to-valid latency is 2 cycles; throughput is at most one access per 2 cycles.
- Boundary conditions:
  - m_ack while in IDLE is ignored.
  - A reset during D_ACC or I_ACC aborts the access: no valid pulse, m_req drops immediately, and a late m_ack after reset is ignored.
  - Requesters must not drop req before valid. If they do, the latched access still completes and the valid pulse is emitted anyway.
  - i_rdata and d_rdata hold their last value until the next completion on that port.
- Widths: all datapaths are DW or AW wide. There is no arithmetic except the timeout counter, which is ceil(log2(TIMEOUT+1)) bits and saturates.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to D_ACC or I_ACC and increments each access cycle without m_ack.
  - When it reaches TIMEOUT: drop m_req, return to IDLE, pulse the owning port's valid with rdata = 0 (loads and fetches only), and set err=1.
  - err is sticky until reset, so the pipeline never hangs.
  - An m_ack arriving in the same cycle the count reaches TIMEOUT takes precedence as a normal completion.
- Undefined: no counter; the FSM waits indefinitely for m_ack; err is tied to 0.

Test Plan:
- Fetch only: i_req=1, i_addr=0x40, memory acks after 3 cycles with 0x8C220004 -> m_addr=0x40, m_we=0, i_valid pulses once, i_rdata=0x8C220004, stall_if=1 until the valid cycle.
- Simultaneous requests: d_req (load 0x100) and i_req (0x44) in the same cycle, ack latency 1 -> data is served first, d_valid precedes i_valid by 2 cycles, second m_addr=0x44.
- Store: d_we=1, d_addr=0x200, d_wdata=0xCAFEF00D -> m_we=1, m_wdata=0xCAFEF00D, d_valid pulses, d_rdata unchanged.
- Reset mid-access: reset=0 two cycles into I_ACC, m_ack arrives after reset is released -> no i_valid, m_req=0, busy=0.
- Spurious ack: m_ack=1 in IDLE with no requests -> no valid pulses, all outputs unchanged.
- ARB_TIMEOUT_EN, TIMEOUT=16: load with no ack -> after 16 cycles m_req=0, d_valid pulses with d_rdata=0, err=1 and stays 1 through later successful accesses.
